// File: rtl/tt_ana_switch_sequencer.sv
// -----------------------------------------------------------------------------
// tt_ana_switch_sequencer
//
// Purpose:
//   Scans NCH analog pass-switches one at a time. Each channel stays enabled
//   for its programmable dwell (in clock cycles). A dwell of 0 removes that
//   channel from the scan. The switches are break-before-make: DEAD all-off
//   cycles come before every channel enable. A scan is either a single pass or
//   continuous. The block pulses a sample strobe on the last enabled cycle of
//   each channel and counts completed passes.
//
// Ports:
//   clk       clock
//   rst       synchronous reset, active-high
//   cfg_we    write dwell register cfg_addr with cfg_data (any state)
//   cfg_addr  channel index; indices >= NCH are ignored
//   cfg_data  dwell value in cycles
//   start     begin a scan (only looked at while idle)
//   stop      request stop at the end of the current dwell (only while busy)
//   mode      0 = single pass, 1 = continuous; captured with start
//   ch_en     one-hot switch enables (registered)
//   ch_idx    index of the current / last selected channel
//   sample    high on the last enabled cycle of a channel
//   busy      scan in progress
//   done      one-cycle pulse when a scan ends
//   pass_cnt  completed passes since reset, wraps at 256
// -----------------------------------------------------------------------------
module tt_ana_switch_sequencer #(
    parameter int NCH   = 6,
    parameter int CNT_W = 8,
    parameter int DEAD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    output logic [NCH-1:0]   ch_en,
    output logic [2:0]       ch_idx,
    output logic             sample,
    output logic             busy,
    output logic             done,
    output logic [7:0]       pass_cnt
);

    // Wide enough to hold DEAD itself; at least one bit so DEAD = 0 still elaborates.
    localparam int GAP_W = (DEAD < 2) ? 1 : $clog2(DEAD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dwell_q [NCH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [2:0]       idx_q, idx_d;
    logic             mode_q, mode_d;
    logic             stop_pend_q, stop_pend_d;
    logic [NCH-1:0]   ch_en_q, ch_en_d;
    logic             done_q, done_d;
    logic [7:0]       pass_q, pass_d;

    // Channel search results
    logic             first_vld, next_vld;
    logic [2:0]       first_idx, next_idx;
    logic [CNT_W-1:0] first_dwell, next_dwell, cur_dwell;

    // Transition requests resolved after the state case
    logic             go_ch, go_idle, sel_next;
    logic [2:0]       tgt_idx;
    logic [CNT_W-1:0] tgt_dwell;
    logic             stop_eff;

    function automatic logic [NCH-1:0] onehot(input logic [2:0] c);
        logic [NCH-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) begin
            if (3'(i) == c) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Dwell registers: written in any state, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) dwell_q[i] <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_addr == 3'(i)) dwell_q[i] <= cfg_data;
            end
        end
    end

    // Priority search on the live dwell values. The scan runs from the top
    // down, so the lowest matching index is the one that remains.
    always_comb begin
        first_vld   = 1'b0;
        first_idx   = '0;
        first_dwell = '0;
        next_vld    = 1'b0;
        next_idx    = '0;
        next_dwell  = '0;
        cur_dwell   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (3'(i) == idx_q) cur_dwell = dwell_q[i];
            if (dwell_q[i] != '0) begin
                first_vld   = 1'b1;
                first_idx   = 3'(i);
                first_dwell = dwell_q[i];
                if (3'(i) > idx_q) begin
                    next_vld   = 1'b1;
                    next_idx   = 3'(i);
                    next_dwell = dwell_q[i];
                end
            end
        end
    end

    // A stop that arrives on the final dwell cycle still counts at that cycle's edge.
    assign stop_eff = stop_pend_q | stop;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        stop_pend_d = stop_pend_q;
        ch_en_d     = ch_en_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        go_ch       = 1'b0;
        go_idle     = 1'b0;
        sel_next    = 1'b0;

        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                ch_en_d     = '0;
                if (start) begin
                    if (first_vld) begin
                        go_ch  = 1'b1;
                        mode_d = mode;
                    end else begin
                        // Nothing to scan: report completion without going busy.
                        done_d = 1'b1;
                    end
                end
            end

            GAP: begin
                if (stop_eff) begin
                    go_idle = 1'b1;
                end else if (gap_q <= GAP_W'(1)) begin
                    // Counter loads at entry, so later writes do not change this dwell.
                    state_d = DWELL;
                    cnt_d   = cur_dwell;
                    ch_en_d = onehot(idx_q);
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            DWELL: begin
                stop_pend_d = stop_pend_q | stop;
                // A count of 0 can only come from a write during GAP. It is
                // treated as a single cycle so the scan cannot stall.
                if (cnt_q <= CNT_W'(1)) begin
                    if (stop_eff) begin
                        go_idle = 1'b1;
                    end else if (next_vld) begin
                        go_ch    = 1'b1;
                        sel_next = 1'b1;
                    end else begin
                        pass_d = pass_q + 8'd1;
                        if (mode_q && first_vld) go_ch = 1'b1;
                        else                     go_idle = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: go_idle = 1'b1;
        endcase

        tgt_idx   = sel_next ? next_idx   : first_idx;
        tgt_dwell = sel_next ? next_dwell : first_dwell;

        if (go_ch) begin
            idx_d = tgt_idx;
            if (DEAD == 0) begin
                state_d = DWELL;
                cnt_d   = tgt_dwell;
                ch_en_d = onehot(tgt_idx);
            end else begin
                state_d = GAP;
                gap_d   = GAP_W'(DEAD);
                ch_en_d = '0;
            end
        end

        if (go_idle) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            ch_en_d     = '0;
            stop_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            idx_q       <= '0;
            mode_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            ch_en_q     <= '0;
            done_q      <= 1'b0;
            pass_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            stop_pend_q <= stop_pend_d;
            ch_en_q     <= ch_en_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign ch_en    = ch_en_q;
    assign ch_idx   = idx_q;
    assign sample   = (state_q == DWELL) && (cnt_q <= CNT_W'(1));
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign pass_cnt = pass_q;

endmodule

// File: tb/tb_tt_ana_switch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tt_ana_switch_sequencer
//
// Purpose:
//   Directed bench for tt_ana_switch_sequencer. Instance "a" (DEAD=2) runs a
//   per-cycle vector table that covers reset, single and continuous scans,
//   stop, an empty scan and dwell rewrites during a scan. Instance "b"
//   (DEAD=0) runs a hand-written continuous scan of one channel until
//   pass_cnt wraps.
// -----------------------------------------------------------------------------
module tb_tt_ana_switch_sequencer;

    logic       clk;
    logic       rst;
    // instance a (DEAD = 2)
    logic       cfg_we, start, stop, mode;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [5:0] ch_en;
    logic [2:0] ch_idx;
    logic       sample, busy, done;
    logic [7:0] pass_cnt;
    // instance b (DEAD = 0)
    logic       cfg_we_b, start_b, stop_b, mode_b;
    logic [2:0] cfg_addr_b;
    logic [7:0] cfg_data_b;
    logic [5:0] ch_en_b;
    logic [2:0] ch_idx_b;
    logic       sample_b, busy_b, done_b;
    logic [7:0] pass_cnt_b;

    int nchk = 0;
    int nerr = 0;

    tt_ana_switch_sequencer #(.NCH(6), .CNT_W(8), .DEAD(2)) u_a (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .stop(stop), .mode(mode), .ch_en(ch_en), .ch_idx(ch_idx),
        .sample(sample), .busy(busy), .done(done), .pass_cnt(pass_cnt)
    );

    tt_ana_switch_sequencer #(.NCH(6), .CNT_W(8), .DEAD(0)) u_b (
        .clk(clk), .rst(rst), .cfg_we(cfg_we_b), .cfg_addr(cfg_addr_b), .cfg_data(cfg_data_b),
        .start(start_b), .stop(stop_b), .mode(mode_b), .ch_en(ch_en_b), .ch_idx(ch_idx_b),
        .sample(sample_b), .busy(busy_b), .done(done_b), .pass_cnt(pass_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
        logic       start;
        logic       stop;
        logic       mode;
        logic [5:0] en;
        logic       smp;
        logic       bsy;
        logic       dn;
        logic [7:0] pc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic r_i, input logic we_i, input logic [2:0] a,
                                input logic [7:0] d, input logic s, input logic p,
                                input logic m, input logic [5:0] en, input logic smp,
                                input logic bsy, input logic dn, input logic [7:0] pc);
        vec_t v;
        v.rst = r_i; v.we = we_i; v.addr = a; v.data = d;
        v.start = s; v.stop = p; v.mode = m;
        v.en = en; v.smp = smp; v.bsy = bsy; v.dn = dn; v.pc = pc;
        return v;
    endfunction

    // Row with only start/stop/mode inputs.
    function automatic vec_t r(input logic s, input logic p, input logic m,
                               input logic [5:0] en, input logic smp, input logic bsy,
                               input logic dn, input logic [7:0] pc);
        return mk(1'b0, 1'b0, 3'd0, 8'd0, s, p, m, en, smp, bsy, dn, pc);
    endfunction

    // Configuration write while idle.
    function automatic vec_t cw(input logic [2:0] a, input logic [7:0] d, input logic [7:0] pc);
        return mk(1'b0, 1'b1, a, d, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, pc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        cfg_we = 0; cfg_addr = 0; cfg_data = 0; start = 0; stop = 0; mode = 0;
        cfg_we_b = 0; cfg_addr_b = 0; cfg_data_b = 0; start_b = 0; stop_b = 0; mode_b = 0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst ch_en", 32'(ch_en), 0);
        chk("rst ch_idx", 32'(ch_idx), 0);
        chk("rst sample", 32'(sample), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst pass_cnt", 32'(pass_cnt), 0);

        // Program dwell = {3,0,1,0,0,2}
        tv.push_back(cw(3'd0, 8'd3, 8'd0));
        tv.push_back(cw(3'd2, 8'd1, 8'd0));
        tv.push_back(cw(3'd5, 8'd2, 8'd0));
        // Single pass, start at cycle 0
        tv.push_back(r(1, 0, 0, 6'b000000, 0, 0, 0, 8'd0));   // 0
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 1
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 2
        tv.push_back(r(0, 0, 0, 6'b000001, 0, 1, 0, 8'd0));   // 3
        tv.push_back(r(0, 0, 0, 6'b000001, 0, 1, 0, 8'd0));   // 4
        tv.push_back(r(0, 0, 0, 6'b000001, 1, 1, 0, 8'd0));   // 5
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 6
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 7
        tv.push_back(r(0, 0, 0, 6'b000100, 1, 1, 0, 8'd0));   // 8
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 9
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 10
        tv.push_back(r(0, 0, 0, 6'b100000, 0, 1, 0, 8'd0));   // 11
        tv.push_back(r(0, 0, 0, 6'b100000, 1, 1, 0, 8'd0));   // 12
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 0, 1, 8'd1));   // 13
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 0, 0, 8'd1));   // 14
        // Continuous scan, reset held two cycles during the ch0 dwell
        tv.push_back(r(1, 0, 1, 6'b000000, 0, 0, 0, 8'd1));
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd1));
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd1));
        tv.push_back(r(0, 0, 0, 6'b000001, 0, 1, 0, 8'd1));
        tv.push_back(mk(1, 0, 3'd0, 8'd0, 0, 0, 0, 6'b000001, 0, 1, 0, 8'd1));
        tv.push_back(mk(1, 0, 3'd0, 8'd0, 0, 0, 0, 6'b000000, 0, 0, 0, 8'd0));
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 0, 0, 8'd0));
        // Dwell regs are now zero: start gives only a done pulse
        tv.push_back(r(1, 0, 0, 6'b000000, 0, 0, 0, 8'd0));
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 0, 1, 8'd0));
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 0, 0, 8'd0));
        // Continuous scan, stop on cycle 8
        tv.push_back(cw(3'd0, 8'd3, 8'd0));
        tv.push_back(cw(3'd2, 8'd1, 8'd0));
        tv.push_back(cw(3'd5, 8'd2, 8'd0));
        tv.push_back(r(1, 0, 1, 6'b000000, 0, 0, 0, 8'd0));   // 0
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 1
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 2
        tv.push_back(r(0, 0, 0, 6'b000001, 0, 1, 0, 8'd0));   // 3
        tv.push_back(r(0, 0, 0, 6'b000001, 0, 1, 0, 8'd0));   // 4
        tv.push_back(r(0, 0, 0, 6'b000001, 1, 1, 0, 8'd0));   // 5
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 6
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 7
        tv.push_back(r(0, 1, 0, 6'b000100, 1, 1, 0, 8'd0));   // 8
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 0, 1, 8'd0));   // 9
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 0, 0, 8'd0));   // 10
        // dwell[0]=2; rewrite dwell[5] 2->4 during ch0, write addr 7, start while busy
        tv.push_back(cw(3'd0, 8'd2, 8'd0));
        tv.push_back(r(1, 0, 0, 6'b000000, 0, 0, 0, 8'd0));   // 0
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 1
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 2
        tv.push_back(mk(0, 1, 3'd5, 8'd4, 0, 0, 0, 6'b000001, 0, 1, 0, 8'd0));  // 3
        tv.push_back(mk(0, 1, 3'd7, 8'd9, 1, 0, 0, 6'b000001, 1, 1, 0, 8'd0));  // 4
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 5
        tv.push_back(r(1, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 6
        tv.push_back(r(0, 0, 0, 6'b000100, 1, 1, 0, 8'd0));   // 7
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 8
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 1, 0, 8'd0));   // 9
        tv.push_back(r(0, 0, 0, 6'b100000, 0, 1, 0, 8'd0));   // 10
        tv.push_back(r(0, 0, 0, 6'b100000, 0, 1, 0, 8'd0));   // 11
        tv.push_back(r(0, 0, 0, 6'b100000, 0, 1, 0, 8'd0));   // 12
        tv.push_back(r(0, 0, 0, 6'b100000, 1, 1, 0, 8'd0));   // 13
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 0, 1, 8'd1));   // 14
        tv.push_back(r(0, 0, 0, 6'b000000, 0, 0, 0, 8'd1));   // 15

        // Each row checks the current cycle's outputs, then drives that cycle's inputs.
        for (int i = 0; i < tv.size(); i++) begin
            chk($sformatf("row%0d ch_en", i), 32'(ch_en), 32'(tv[i].en));
            chk($sformatf("row%0d sample", i), 32'(sample), 32'(tv[i].smp));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tv[i].bsy));
            chk($sformatf("row%0d done", i), 32'(done), 32'(tv[i].dn));
            chk($sformatf("row%0d pass_cnt", i), 32'(pass_cnt), 32'(tv[i].pc));
            rst      = tv[i].rst;
            cfg_we   = tv[i].we;
            cfg_addr = tv[i].addr;
            cfg_data = tv[i].data;
            start    = tv[i].start;
            stop     = tv[i].stop;
            mode     = tv[i].mode;
            tick();
        end
        rst = 0; cfg_we = 0; start = 0; stop = 0; mode = 0;
        chk("last ch_idx", 32'(ch_idx), 5);

        // DEAD=0, dwell[0]=1 only, continuous: ch0 stays on and pass_cnt wraps
        cfg_we_b = 1; cfg_addr_b = 3'd0; cfg_data_b = 8'd1;
        tick();
        cfg_we_b = 0;
        start_b = 1; mode_b = 1;
        chk("b pre ch_en", 32'(ch_en_b), 0);
        tick();
        start_b = 0; mode_b = 0;
        for (int k = 1; k <= 257; k++) begin
            chk($sformatf("b cyc%0d ch_en", k), 32'(ch_en_b), 1);
            chk($sformatf("b cyc%0d sample", k), 32'(sample_b), 1);
            chk($sformatf("b cyc%0d busy", k), 32'(busy_b), 1);
            chk($sformatf("b cyc%0d pass_cnt", k), 32'(pass_cnt_b), 32'((k - 1) % 256));
            tick();
        end
        chk("b ch_idx", 32'(ch_idx_b), 0);
        chk("b pass before stop", 32'(pass_cnt_b), 1);
        stop_b = 1;
        tick();
        stop_b = 0;
        chk("b stop done", 32'(done_b), 1);
        chk("b stop busy", 32'(busy_b), 0);
        chk("b stop ch_en", 32'(ch_en_b), 0);
        chk("b stop pass_cnt", 32'(pass_cnt_b), 1);
        tick();
        chk("b done pulse width", 32'(done_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
